// File: rtl/ffjk_bank_if.sv
// ffjk_bank_if: control/data bundle for the ffjk_bank JK register bank.
//   enable  : bank update enable (1 = update on clock edge, 0 = hold)
//   mode    : 00 JK, 01 count up, 10 count down, 11 shift left
//   j, k    : per-bit JK controls (JK mode only)
//   sin     : serial input into q[0] (shift mode only)
//   q       : registered bank state
//   tc      : terminal count (combinational)
//   sout    : serial output, always q[WIDTH-1]
// master drives the controls; slave (the bank) drives q/tc/sout.
interface ffjk_bank_if #(
    parameter int unsigned WIDTH = 4
);
    logic             enable;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             sout;

    modport master (
        output enable, mode, j, k, sin,
        input  q, tc, sout
    );

    modport slave (
        input  enable, mode, j, k, sin,
        output q, tc, sout
    );
endinterface

// File: rtl/ffjk_bank.sv
// ffjk_bank: WIDTH JK flip-flops sharing one enable. Every mode is realised
// by generating per-bit J/K values and feeding a common JK cell update:
//   00 JK     : j/k taken directly from the bus
//   01 up     : bit i toggles when bits 0..i-1 are all 1
//   10 down   : bit i toggles when bits 0..i-1 are all 0
//   11 shift  : each bit is set/cleared to the value of its lower neighbour
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, loads RST_VAL
//   bus  : ffjk_bank_if slave (enable, mode, j, k, sin -> q, tc, sout)
module ffjk_bank #(
    parameter int unsigned          WIDTH   = 4,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    ffjk_bank_if.slave    bus
);
    typedef enum logic [1:0] {
        MODE_JK  = 2'b00,
        MODE_UP  = 2'b01,
        MODE_DN  = 2'b10,
        MODE_SHL = 2'b11
    } mode_t;

    mode_t            mode;
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] state_next;
    logic [WIDTH-1:0] jv;
    logic [WIDTH-1:0] kv;
    logic [WIDTH-1:0] shifted;

    assign mode    = mode_t'(bus.mode);
    assign shifted = {state[WIDTH-2:0], bus.sin};

    // Per-bit J/K generation for the selected mode.
    always_comb begin
        logic run;
        jv  = '0;
        kv  = '0;
        run = 1'b1;
        case (mode)
            MODE_JK: begin
                jv = bus.j;
                kv = bus.k;
            end
            MODE_UP: begin
                // Toggle chain: run stays 1 while all lower bits are 1.
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    jv[i] = run;
                    kv[i] = run;
                    run   = run & state[i];
                end
            end
            MODE_DN: begin
                // Borrow chain: run stays 1 while all lower bits are 0.
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    jv[i] = run;
                    kv[i] = run;
                    run   = run & ~state[i];
                end
            end
            MODE_SHL: begin
                // Load the neighbour value via set (j) / clear (k).
                jv = shifted;
                kv = ~shifted;
            end
            default: begin
                jv = '0;
                kv = '0;
            end
        endcase
    end

    // JK cell: set when j & ~q, keep when ~k & q.
    assign state_next = (jv & ~state) | (~kv & state);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_VAL;
        end else if (bus.enable) begin
            state <= state_next;
        end
    end

    assign bus.q    = state;
    assign bus.sout = state[WIDTH-1];
    assign bus.tc   = bus.enable & (((mode == MODE_UP) & (&state)) |
                                    ((mode == MODE_DN) & ~(|state)));
endmodule
